nios_pio_in_edge: RTL and testbench



---
 rtl/nios_pio_in_edge_if.sv | 19 +
 rtl/nios_pio_in_edge.sv | 126 ++++++++++++
 tb/tb_nios_pio_in_edge.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_pio_in_edge_if.sv
// Avalon-MM slave register window for the input PIO: 2-bit word address,
// 32-bit data, zero-latency combinational read data.
interface nios_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_pio_in_edge.sv
// Input PIO: 2-flop synchronizer, optional per-bit debouncer, sticky edge
// capture with write-1-to-clear, and a maskable level interrupt.
module nios_pio_in_edge #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    nios_pio_in_edge_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] db_prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;
    logic [31:0]      rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            s1_q      <= in_port;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign db_d = s2_q;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
            localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q [WIDTH];
            logic [CW-1:0] cnt_d [WIDTH];

            // Each bit counts consecutive cycles of disagreement with db;
            // any agreement restarts the count, so short glitches never land.
            always_comb begin
                db_d = db_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = cnt_q[i];
                    if (s2_q[i] == db_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_TC) begin
                        db_d[i]  = s2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = db_q & ~db_prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~db_q & db_prev_q;
        end else begin : g_any
            assign edge_det = db_q ^ db_prev_q;
        end
    endgenerate

    assign wr_en = bus.chipselect & ~bus.write_n;

    always_comb begin
        irqmask_d = irqmask_q;
        clr_mask  = '0;
        if (wr_en) begin
            case (bus.address)
                2'd2:    irqmask_d = bus.writedata[WIDTH-1:0];
                2'd3:    clr_mask  = bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        // A new edge on the same bit wins over a software clear.
        edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            2'd0:    rd_data[WIDTH-1:0] = db_q;
            2'd2:    rd_data[WIDTH-1:0] = irqmask_q;
            2'd3:    rd_data[WIDTH-1:0] = edgecap_q;
            default: ;
        endcase
    end

    assign bus.readdata = rd_data;
    assign irq          = |(edgecap_q & irqmask_q);

    generate
        if (WIDTH < 32) begin : g_pad
            logic unused_wdata;
            assign unused_wdata = ^bus.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Bench for nios_pio_in_edge: three parameterisations share one input bus and
// are compared every cycle against a window-based reference model.
module tb_nios_pio_in_edge;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    logic         irq0, irq1, irq2;

    always #5 clk = ~clk;

    nios_pio_in_edge_if b0 ();
    nios_pio_in_edge_if b1 ();
    nios_pio_in_edge_if b2 ();

    nios_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0), .in_port(in_port), .irq(irq0));
    nios_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .in_port(in_port), .irq(irq1));
    nios_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(1)) u2 (
        .clk(clk), .reset(reset), .bus(b2), .in_port(in_port), .irq(irq2));

    int vectors = 0;
    int miscompares = 0;

    // Reference state: synchronizer taps, debounced value, previous value,
    // mask, capture, and the recent s2 history used by the debounce window.
    logic [W-1:0] m_s1 [3];
    logic [W-1:0] m_s2 [3];
    logic [W-1:0] m_db [3];
    logic [W-1:0] m_dbp [3];
    logic [W-1:0] m_ec [3];
    logic [W-1:0] m_mask [3];
    logic [W-1:0] m_hist [3][4];
    int           m_hcnt [3];

    function automatic int ncyc(int j);
        case (j)
            0: return 0;
            1: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int etype(int j);
        case (j)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] rd_of(int j);
        case (j)
            0: return b0.readdata;
            1: return b1.readdata;
            default: return b2.readdata;
        endcase
    endfunction

    function automatic logic irq_of(int j);
        case (j)
            0: return irq0;
            1: return irq1;
            default: return irq2;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(int j, logic [1:0] a);
        case (a)
            2'd0: return 32'(m_db[j]);
            2'd2: return 32'(m_mask[j]);
            2'd3: return 32'(m_ec[j]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        b0.address = a; b0.chipselect = cs; b0.write_n = wn; b0.writedata = wd;
        b1.address = a; b1.chipselect = cs; b1.write_n = wn; b1.writedata = wd;
        b2.address = a; b2.chipselect = cs; b2.write_n = wn; b2.writedata = wd;
    endtask

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic model_step();
        logic         wr;
        logic [W-1:0] clr, edges, db_n, all_v, any_v;
        int           n;
        wr = b0.chipselect && !b0.write_n;
        for (int j = 0; j < 3; j++) begin
            if (reset) begin
                m_s1[j] = '0; m_s2[j] = '0; m_db[j] = '0; m_dbp[j] = '0;
                m_ec[j] = '0; m_mask[j] = '0; m_hcnt[j] = 0;
                for (int k = 0; k < 4; k++) m_hist[j][k] = '0;
            end else begin
                n = ncyc(j);
                db_n = m_db[j];
                if (n == 0) begin
                    db_n = m_s2[j];
                end else begin
                    for (int k = 3; k > 0; k--) m_hist[j][k] = m_hist[j][k-1];
                    m_hist[j][0] = m_s2[j];
                    if (m_hcnt[j] < n) m_hcnt[j]++;
                    if (m_hcnt[j] >= n) begin
                        // A bit follows s2 once its last n samples all agree.
                        all_v = '1; any_v = '0;
                        for (int k = 0; k < n; k++) begin
                            all_v &= m_hist[j][k];
                            any_v |= m_hist[j][k];
                        end
                        db_n = (m_db[j] | all_v) & any_v;
                    end
                end
                case (etype(j))
                    0: edges = m_db[j] & ~m_dbp[j];
                    1: edges = ~m_db[j] & m_dbp[j];
                    default: edges = m_db[j] ^ m_dbp[j];
                endcase
                clr = (wr && b0.address == 2'd3) ? b0.writedata[W-1:0] : '0;
                m_ec[j] = (m_ec[j] & ~clr) | edges;
                if (wr && b0.address == 2'd2) m_mask[j] = b0.writedata[W-1:0];
                m_dbp[j] = m_db[j];
                m_db[j]  = db_n;
                m_s2[j]  = m_s1[j];
                m_s1[j]  = in_port;
            end
        end
    endtask

    // Called at a falling edge with inputs applied: check, step model, clock.
    task automatic cyc(input bit do_chk = 1'b1);
        #1;
        if (do_chk) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("rd%0d_a%0d", j, b0.address), rd_of(j), exp_rd(j, b0.address));
                chk($sformatf("irq%0d", j), 32'(irq_of(j)), 32'(|(m_ec[j] & m_mask[j])));
            end
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rdchk(input int j, input logic [1:0] a, input logic [31:0] exp, input string tag);
        drive(a, 1'b0, 1'b1, 32'h0);
        #1;
        chk(tag, rd_of(j), exp);
    endtask

    task automatic idle_cycles(input int n);
        drive(2'd0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            m_s1[j] = '0; m_s2[j] = '0; m_db[j] = '0; m_dbp[j] = '0;
            m_ec[j] = '0; m_mask[j] = '0; m_hcnt[j] = 0;
            for (int k = 0; k < 4; k++) m_hist[j][k] = '0;
        end
        reset = 1'b1;
        in_port = '0;
        drive(2'd0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        cyc(1'b0);
        cyc(1'b0);
        cyc();
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            rdchk(0, 2'(a), 32'h0, "rst_read");
            cyc();
        end
        chk("rst_irq", 32'(irq0), 32'h0);
        drive(2'd2, 1'b1, 1'b0, 32'hF);
        cyc();
        rdchk(0, 2'd2, 32'hF, "mask_wr");
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rdchk(0, 2'd2, 32'h0, "mask_after_rst");
        cyc();

        // Latency through synchronizer and capture, N=0 rising
        drive(2'd2, 1'b1, 1'b0, 32'h1);
        cyc();
        drive(2'd0, 1'b0, 1'b1, 32'h0);
        in_port = 4'h1;
        cyc();                               // edge 0
        cyc();                               // edge 1
        rdchk(0, 2'd0, 32'h0, "db_early");
        cyc();                               // edge 2
        rdchk(0, 2'd0, 32'h1, "db_lat");
        cyc();                               // edge 3
        rdchk(0, 2'd3, 32'h1, "ec_lat");
        chk("irq_lat", 32'(irq0), 32'h1);
        drive(2'd3, 1'b1, 1'b0, 32'h1);
        cyc();
        rdchk(0, 2'd3, 32'h0, "ec_clr");
        chk("irq_clr", 32'(irq0), 32'h0);
        cyc();

        // Debounce N=4: short glitch rejected, stable level accepted
        in_port = 4'h0;
        idle_cycles(8);
        drive(2'd3, 1'b1, 1'b0, 32'hF);
        cyc();
        in_port = 4'h1;
        idle_cycles(3);
        in_port = 4'h0;
        for (int k = 0; k < 8; k++) begin
            rdchk(1, 2'd0, 32'h0, "glitch_db");
            cyc();
        end
        rdchk(1, 2'd3, 32'h0, "glitch_ec");
        cyc();
        in_port = 4'h1;
        for (int k = 0; k < 5; k++) begin    // edges 0..4
            cyc();
            rdchk(1, 2'd0, 32'h0, "deb_hold");
        end
        cyc();                               // edge 5
        rdchk(1, 2'd0, 32'h1, "deb_db");
        cyc();                               // edge 6
        rdchk(1, 2'd3, 32'h1, "deb_ec");
        cyc();

        // Any-edge capture while masked, then unmask
        drive(2'd2, 1'b1, 1'b0, 32'h0);
        cyc();
        drive(2'd3, 1'b1, 1'b0, 32'hF);
        cyc();
        in_port = 4'h5;
        idle_cycles(8);
        in_port = 4'h1;
        idle_cycles(8);
        rdchk(1, 2'd3, 32'h4, "any_ec");
        chk("any_irq_masked", 32'(irq1), 32'h0);
        cyc();
        drive(2'd2, 1'b1, 1'b0, 32'h4);
        cyc();
        rdchk(1, 2'd2, 32'h4, "any_mask");
        chk("any_irq_unmasked", 32'(irq1), 32'h1);
        cyc();

        // Clear and new edge on the same edge: set wins
        in_port = 4'h0;
        idle_cycles(6);
        drive(2'd3, 1'b1, 1'b0, 32'hF);
        cyc();
        in_port = 4'h3;
        idle_cycles(6);
        in_port = 4'h1;
        idle_cycles(6);
        rdchk(0, 2'd3, 32'h3, "pre_sim");
        cyc();
        in_port = 4'h3;
        cyc();                               // edge 0
        cyc();                               // edge 1
        cyc();                               // edge 2
        drive(2'd3, 1'b1, 1'b0, 32'h3);
        cyc();                               // edge 3: capture and clear together
        rdchk(0, 2'd3, 32'h2, "sim_ec");
        cyc();

        // Reset mid-operation with a write on the reset edge
        drive(2'd2, 1'b1, 1'b0, 32'hF);
        cyc();
        in_port = 4'h0;
        idle_cycles(6);
        in_port = 4'hF;
        idle_cycles(6);
        rdchk(0, 2'd3, 32'hF, "pre_rst_ec");
        chk("pre_rst_irq", 32'(irq0), 32'h1);
        reset = 1'b1;
        drive(2'd2, 1'b1, 1'b0, 32'h5);
        cyc();
        reset = 1'b0;
        rdchk(0, 2'd2, 32'h0, "rst_mid_mask");
        cyc();
        rdchk(0, 2'd3, 32'h0, "rst_mid_ec");
        chk("rst_mid_irq", 32'(irq0), 32'h0);
        cyc();

        // Randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) in_port = W'($urandom);
            reset = ($urandom_range(199) == 0);
            drive(2'($urandom), ($urandom_range(3) == 0), ($urandom_range(1) == 0), $urandom);
            cyc();
        end
        reset = 1'b0;
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
